// File: rtl/triangle_raster_scan.sv
// Triangle raster scanner: latches a triangle, walks its bounding box in raster order and
// streams one pixel beat per cycle with an inside flag. Optional macro: TRI_ANY_WINDING_EN.
module triangle_raster_scan #(
    parameter int COORD_W = 12,
    parameter int CNT_W   = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] px1,
    input  logic [COORD_W-1:0] py1,
    input  logic [COORD_W-1:0] px2,
    input  logic [COORD_W-1:0] py2,
    input  logic [COORD_W-1:0] px3,
    input  logic [COORD_W-1:0] py3,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_inside,
    output logic               out_last,
    output logic               done,
    output logic [CNT_W-1:0]   hit_count
);
    localparam int EW = 2*COORD_W+3;

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, FIN} state_t;
    state_t state;

    logic [COORD_W-1:0] vx1_p0, vy1_p0, vx2_p0, vy2_p0, vx3_p0, vy3_p0;
    logic [COORD_W-1:0] xmin_p1, xmax_p1, ymin_p1, ymax_p1;
    logic [COORD_W-1:0] bxmin, bxmax, bymin, bymax, cxmax, cymax;
    logic [COORD_W-1:0] nx, ny;
    logic               wrap, nlast, nins;
    logic signed [EW-1:0] e1, e2, e3;

    function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Full-precision edge function: no bit of the products or their difference is dropped.
    function automatic logic signed [EW-1:0] edge_fn(
        input logic [COORD_W-1:0] ax, ay, bx, by, qx, qy);
        logic signed [COORD_W:0]     dqx, day, dax, dqy;
        logic signed [2*COORD_W+1:0] m0, m1;
        dqx = $signed({1'b0, qx}) - $signed({1'b0, bx});
        day = $signed({1'b0, ay}) - $signed({1'b0, by});
        dax = $signed({1'b0, ax}) - $signed({1'b0, bx});
        dqy = $signed({1'b0, qy}) - $signed({1'b0, by});
        m0  = dqx * day;
        m1  = dax * dqy;
        return $signed({m0[2*COORD_W+1], m0}) - $signed({m1[2*COORD_W+1], m1});
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign bxmin = min3(vx1_p0, vx2_p0, vx3_p0);
    assign bxmax = max3(vx1_p0, vx2_p0, vx3_p0);
    assign bymin = min3(vy1_p0, vy2_p0, vy3_p0);
    assign bymax = max3(vy1_p0, vy2_p0, vy3_p0);

    // Next pixel: the bbox itself in SETUP, otherwise the raster successor of the current beat.
    always_comb begin
        wrap  = (out_x == xmax_p1);
        cxmax = xmax_p1;
        cymax = ymax_p1;
        nx    = wrap ? xmin_p1 : out_x + COORD_W'(1);
        ny    = wrap ? out_y + COORD_W'(1) : out_y;
        if (state == SETUP) begin
            nx    = bxmin;
            ny    = bymin;
            cxmax = bxmax;
            cymax = bymax;
        end
        nlast = (nx == cxmax) && (ny == cymax);
        e1    = edge_fn(vx1_p0, vy1_p0, vx2_p0, vy2_p0, nx, ny);
        e2    = edge_fn(vx2_p0, vy2_p0, vx3_p0, vy3_p0, nx, ny);
        e3    = edge_fn(vx3_p0, vy3_p0, vx1_p0, vy1_p0, nx, ny);
`ifdef TRI_ANY_WINDING_EN
        nins  = (!e1[EW-1] && !e2[EW-1] && !e3[EW-1]) ||
                ((e1[EW-1] || e1 == '0) && (e2[EW-1] || e2 == '0) && (e3[EW-1] || e3 == '0));
`else
        nins  = !e1[EW-1] && !e2[EW-1] && !e3[EW-1];
`endif
    end

    // Stage p0: triangle capture; stage p1: bounding box.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            vx1_p0 <= px1;
            vy1_p0 <= py1;
            vx2_p0 <= px2;
            vy2_p0 <= py2;
            vx3_p0 <= px3;
            vy3_p0 <= py3;
        end
        if (state == SETUP) begin
            xmin_p1 <= bxmin;
            xmax_p1 <= bxmax;
            ymin_p1 <= bymin;
            ymax_p1 <= bymax;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_inside <= 1'b0;
            out_last   <= 1'b0;
            done       <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            hit_count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    hit_count <= '0;
                    busy      <= 1'b1;
                    state     <= SETUP;
                end
                SETUP: begin
                    out_x      <= nx;
                    out_y      <= ny;
                    out_inside <= nins;
                    out_last   <= nlast;
                    out_valid  <= 1'b1;
                    state      <= SCAN;
                end
                SCAN: if (out_valid && out_ready) begin
                    if (out_inside) hit_count <= sat_inc(hit_count);
                    if (out_last) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end else begin
                        out_x      <= nx;
                        out_y      <= ny;
                        out_inside <= nins;
                        out_last   <= nlast;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_triangle_raster_scan.sv
// Scoreboard bench for triangle_raster_scan: a bbox-walking reference model queues expected
// beats; a negedge monitor pops and checks them, plus stall stability and the done pulse.
module tb_triangle_raster_scan;
    localparam int CW = 12;
    localparam int NW = 24;
`ifdef TRI_ANY_WINDING_EN
    localparam int C3_HITS = 6;
`else
    localparam int C3_HITS = 0;
`endif

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
    logic [CW-1:0] px1 = '0, py1 = '0, px2 = '0, py2 = '0, px3 = '0, py3 = '0;
    logic          busy, out_valid, out_inside, out_last, done;
    logic [CW-1:0] out_x, out_y;
    logic [NW-1:0] hit_count;

    triangle_raster_scan #(.COORD_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .px1(px1), .py1(py1), .px2(px2), .py2(py2), .px3(px3), .py3(py3),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_inside(out_inside), .out_last(out_last),
        .done(done), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          ins;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0, bad = 0, beats = 0, rmode = 0;
    bit    expect_done = 1'b0, held_v = 1'b0;
    beat_t held;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint ef(longint ax, ay, bx, by, qx, qy);
        return (qx - bx) * (ay - by) - (ax - bx) * (qy - by);
    endfunction

    // Reference: visit every bbox pixel row by row and apply the three edge tests.
    task automatic model(input int x1, y1, x2, y2, x3, y3, output int hits, output int n);
        int xl, xh, yl, yh;
        longint a, b, c;
        bit ins;
        beat_t bt;
        xl = x1 < x2 ? x1 : x2; xl = x3 < xl ? x3 : xl;
        xh = x1 > x2 ? x1 : x2; xh = x3 > xh ? x3 : xh;
        yl = y1 < y2 ? y1 : y2; yl = y3 < yl ? y3 : yl;
        yh = y1 > y2 ? y1 : y2; yh = y3 > yh ? y3 : yh;
        hits = 0;
        n = 0;
        for (int y = yl; y <= yh; y++) begin
            for (int x = xl; x <= xh; x++) begin
                a = ef(x1, y1, x2, y2, x, y);
                b = ef(x2, y2, x3, y3, x, y);
                c = ef(x3, y3, x1, y1, x, y);
                ins = (a >= 0 && b >= 0 && c >= 0);
`ifdef TRI_ANY_WINDING_EN
                ins = ins || (a <= 0 && b <= 0 && c <= 0);
`endif
                bt.x = CW'(x);
                bt.y = CW'(y);
                bt.ins = ins;
                bt.last = (x == xh) && (y == yh);
                exp_q.push_back(bt);
                hits += int'(ins);
                n++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    initial forever begin
        beat_t cur, e;
        @(negedge clk);
        cur = {out_x, out_y, out_inside, out_last};
        if (reset) begin
            held_v = 1'b0;
            expect_done = 1'b0;
        end else begin
            if (expect_done || done) chk("done_pulse", done, expect_done);
            expect_done = 1'b0;
            if (held_v) chk("stall_hold", {out_valid, cur}, {1'b1, held});
            if (out_valid && out_ready) begin
                chk("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    total++;
                    if (cur != e) begin
                        bad++;
                        $display("FAIL beat%0d got x=%0d y=%0d in=%0d last=%0d want x=%0d y=%0d in=%0d last=%0d",
                                 beats, cur.x, cur.y, cur.ins, cur.last, e.x, e.y, e.ins, e.last);
                    end
                end
                beats++;
                expect_done = cur.last;
                held_v = 1'b0;
            end else if (out_valid) begin
                held_v = 1'b1;
                held = cur;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic run_tri(input int x1, y1, x2, y2, x3, y3, input int mode,
                           input int abort_at, input string tag);
        int  hits, n;
        bit  seen;
        model(x1, y1, x2, y2, x3, y3, hits, n);
        beats = 0;
        rmode = mode;
        @(posedge clk);
        #1;
        px1 = CW'(x1); py1 = CW'(y1); px2 = CW'(x2); py2 = CW'(y2); px3 = CW'(x3); py3 = CW'(y3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1);
        chk({tag, "_valid_early"}, out_valid, 0);
        @(posedge clk);
        #1;
        chk({tag, "_valid_latency"}, out_valid, 1);
        if (mode == 2) begin
            px1 = '0; py1 = '0; px2 = 2; py2 = '0; px3 = '0; py3 = 2;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (3) @(posedge clk);
            rmode = 0;
        end
        if (abort_at > 0) begin
            for (int i = 0; i < 4000 && beats < abort_at; i++) @(negedge clk);
            chk({tag, "_abort_reached"}, beats >= abort_at, 1);
            @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #1;
            chk({tag, "_abort_valid"}, out_valid, 0);
            chk({tag, "_abort_busy"}, busy, 0);
            chk({tag, "_abort_done"}, done, 0);
            chk({tag, "_abort_hits"}, hit_count, 0);
            reset = 1'b0;
            exp_q.delete();
            repeat (6) @(posedge clk);
            return;
        end
        seen = 1'b0;
        for (int i = 0; i < 6000 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_beats"}, beats, n);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_hits"}, hit_count, hits);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_busy_idle"}, busy, 0);
        chk({tag, "_hits_hold"}, hit_count, hits);
        exp_q.delete();
    endtask

    initial begin
        int bx, by;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_x", out_x, 0);
        chk("rst_y", out_y, 0);
        chk("rst_last", out_last, 0);
        chk("rst_inside", out_inside, 0);
        reset = 1'b0;

        run_tri(10, 10, 30, 10, 20, 30, 0, 0, "c1");
        chk("c1_beat_count", beats, 441);
        run_tri(0, 0, 2, 0, 0, 2, 0, 0, "c2");
        chk("c2_hit_count", hit_count, 6);
        run_tri(0, 0, 0, 2, 2, 0, 0, 0, "c3");
        chk("c3_hit_count", hit_count, C3_HITS);
        run_tri(10, 10, 30, 10, 20, 30, 1, 0, "c4");
        chk("c4_beat_count", beats, 441);
        run_tri(10, 10, 30, 10, 20, 30, 1, 100, "c5a");
        run_tri(10, 10, 30, 10, 20, 30, 0, 0, "c5b");
        run_tri(4095, 4095, 4095, 4095, 4095, 4095, 2, 0, "c6");
        chk("c6_beat_count", beats, 1);
        chk("c6_hit_count", hit_count, 1);
        for (int k = 0; k < 6; k++) begin
            bx = (k % 2 == 0) ? int'($urandom_range(0, 4080)) : 4080;
            by = (k % 3 == 0) ? 4080 : int'($urandom_range(0, 4080));
            run_tri(bx + int'($urandom_range(0, 15)), by + int'($urandom_range(0, 15)),
                    bx + int'($urandom_range(0, 15)), by + int'($urandom_range(0, 15)),
                    bx + int'($urandom_range(0, 15)), by + int'($urandom_range(0, 15)),
                    1, 0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
